// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern generator with repeat and gap. The first bit is on x one cycle after start.
// No backpressure: bits stream one per clock. start is taken only while idle, and abort drops the transfer.
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1),
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    nbits,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LW-1:0] NMAX = LW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] pat;
    logic [IW-1:0]    last;
    logic [IW-1:0]    idx;
    logic [REP_W-1:0] frm;
    logic [GAP_W-1:0] gap_len;
    logic [GAP_W-1:0] gcnt;

    logic [LW-1:0] nm1;
    logic          nb_ok;
    assign nm1   = nbits - LW'(1);
    assign nb_ok = (nbits != '0) && (nbits <= NMAX);

    // idx always names the bit currently on x, so the first bit is driven at the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pat     <= '0;
            last    <= '0;
            idx     <= '0;
            frm     <= '0;
            gap_len <= '0;
            gcnt    <= '0;
            x       <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                x     <= 1'b0;
                valid <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (nb_ok) begin
                                pat     <= pattern;
                                last    <= nm1[IW-1:0];
                                idx     <= nm1[IW-1:0];
                                frm     <= reps;
                                gap_len <= gap;
                                x       <= pattern[nm1[IW-1:0]];
                                valid   <= 1'b1;
                                busy    <= 1'b1;
                                state   <= SHIFT;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    SHIFT: begin
                        if (idx != '0) begin
                            idx <= idx - IW'(1);
                            x   <= pat[idx - IW'(1)];
                        end else if (frm != '0) begin
                            frm <= frm - REP_W'(1);
                            if (gap_len != '0) begin
                                gcnt  <= gap_len;
                                x     <= 1'b0;
                                valid <= 1'b0;
                                state <= GAP;
                            end else begin
                                idx <= last;
                                x   <= pat[last];
                            end
                        end else begin
                            x     <= 1'b0;
                            valid <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    GAP: begin
                        if (gcnt == GAP_W'(1)) begin
                            idx   <= last;
                            x     <= pat[last];
                            valid <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            gcnt <= gcnt - GAP_W'(1);
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a vector table, hand-written abort/reset sequences, and randomized transfers checked against a frame-list model.
module tb_seq_pattern_gen;
    localparam int WIDTH = 8;
    localparam int LW    = $clog2(WIDTH + 1);
    localparam int REP_W = 4;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             reset, start, abort;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    nbits;
    logic [REP_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             x, valid, busy, done, err;

    int tests = 0;
    int fails = 0;

    seq_pattern_gen #(.WIDTH(WIDTH), .LW(LW), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .nbits(nbits), .reps(reps), .gap(gap),
        .x(x), .valid(valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] p;
        int n;
        int r;
        int g;
        int exp_done;
        int exp_err;
        int exp_match;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {x, valid, busy, done, err};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: x/valid/busy/done/err got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_xfer(input logic [WIDTH-1:0] p, input int n, input int r, input int g);
        pattern = p;
        nbits   = LW'(n);
        reps    = REP_W'(r);
        gap     = GAP_W'(g);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Expected stream is built frame by frame from the parameters; exp_match < 0 means derive it from that stream.
    task automatic run(input vec_t v, input bit scramble, input string name);
        logic qx[$];
        logic qv[$];
        logic [3:0] hist;
        int len, done_at, m, mm;
        logic [4:0] e;
        if (v.exp_err == 0) begin
            for (int f = 0; f <= v.r; f++) begin
                for (int b = v.n - 1; b >= 0; b--) begin
                    qx.push_back(v.p[b]);
                    qv.push_back(1'b1);
                end
                if (f < v.r)
                    for (int k = 0; k < v.g; k++) begin
                        qx.push_back(1'b0);
                        qv.push_back(1'b0);
                    end
            end
        end
        len = qx.size();
        hist = 4'b0;
        mm = 0;
        for (int i = 0; i < len; i++) begin
            hist = {hist[2:0], qx[i]};
            if (hist == 4'b1011) mm++;
        end
        if (v.exp_match >= 0) mm = v.exp_match;

        start_xfer(v.p, v.n, v.r, v.g);
        if (v.exp_err != 0) begin
            chk({name, " err pulse"}, outs(), 5'b00001);
            tick();
            chk({name, " err clear"}, outs(), 5'b00000);
            tick();
            chk({name, " no transfer"}, outs(), 5'b00000);
            return;
        end

        done_at = 0;
        m = 0;
        hist = 4'b0;
        for (int c = 1; c <= len + 2; c++) begin
            if (c <= len)          e = {qx[c-1], qv[c-1], 3'b100};
            else if (c == len + 1) e = 5'b00110;
            else                   e = 5'b00000;
            chk($sformatf("%s cycle %0d", name, c), outs(), e);
            if (done && done_at == 0) done_at = c;
            hist = {hist[2:0], x};
            if (hist == 4'b1011) m++;
            if (scramble && c <= len + 1) begin
                start   = 1'($urandom_range(0, 1));
                pattern = WIDTH'($urandom);
                nbits   = LW'($urandom);
                reps    = REP_W'($urandom);
                gap     = GAP_W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk({name, " idle after"}, outs(), 5'b00000);
        chk_int({name, " done cycle"}, done_at, v.exp_done);
        chk_int({name, " 1011 matches"}, m, mm);
    endtask

    vec_t vecs[9];
    logic [11:0] s;

    initial begin
        vecs[0] = '{8'h0B, 4, 0, 0, 5, 0, 1};
        vecs[1] = '{8'h0B, 4, 2, 0, 13, 0, 3};
        vecs[2] = '{8'h0B, 4, 2, 3, 19, 0, 3};
        vecs[3] = '{8'hA5, 8, 15, 15, 354, 0, 0};
        vecs[4] = '{8'hFF, 0, 1, 1, 0, 1, 0};
        vecs[5] = '{8'hFF, 9, 0, 0, 0, 1, 0};
        vecs[6] = '{8'h80, 1, 0, 0, 2, 0, 0};
        vecs[7] = '{8'h81, 1, 3, 0, 5, 0, 0};
        vecs[8] = '{8'h0D, 4, 1, 1, 10, 0, 1};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; nbits = '0; reps = '0; gap = '0;
        repeat (3) tick();
        chk("reset state", outs(), 5'b00000);
        reset = 1'b0;
        tick();
        chk("idle after reset", outs(), 5'b00000);

        for (int i = 0; i < 9; i++)
            run(vecs[i], i == 1 || i == 2, $sformatf("vec%0d", i));

        // Abort on the 3rd bit of frame 2.
        s = 12'b1011_1011_1011;
        start_xfer(8'h0B, 4, 2, 0);
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("abort run cycle %0d", c), outs(), {s[12-c], 4'b1100});
            if (c == 7) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        for (int c = 8; c <= 12; c++) begin
            chk($sformatf("after abort cycle %0d", c), outs(), 5'b00000);
            tick();
        end

        // start together with abort in IDLE: start wins.
        pattern = 8'h0B; nbits = LW'(4); reps = '0; gap = '0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("start+abort cycle %0d", c), outs(),
                c <= 4 ? {s[12-c], 4'b1100} : (c == 5 ? 5'b00110 : 5'b00000));
            tick();
        end

        // Reset in the middle of a gap.
        start_xfer(8'h0B, 4, 2, 3);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("pre-reset gap run cycle %0d", c), outs(),
                c <= 4 ? {s[12-c], 4'b1100} : 5'b00100);
            if (c == 6) reset = 1'b1;
            tick();
        end
        chk("reset in gap", outs(), 5'b00000);
        reset = 1'b0;
        tick();
        chk("idle after gap reset", outs(), 5'b00000);

        // Reset in the middle of a frame.
        start_xfer(8'h0B, 4, 0, 0);
        chk("pre-reset shift cycle 1", outs(), 5'b11100);
        tick();
        chk("pre-reset shift cycle 2", outs(), 5'b01100);
        reset = 1'b1;
        tick();
        chk("reset in shift", outs(), 5'b00000);
        reset = 1'b0;
        tick();
        chk("idle after shift reset", outs(), 5'b00000);
        run(vecs[0], 1'b0, "post-reset frame");

        for (int t = 0; t < 30; t++) begin
            vec_t v;
            v.p = WIDTH'($urandom);
            v.n = $urandom_range(1, WIDTH);
            v.r = $urandom_range(0, 3);
            v.g = $urandom_range(0, 3);
            v.exp_done  = (v.r + 1) * v.n + v.r * v.g + 1;
            v.exp_err   = 0;
            v.exp_match = -1;
            run(v, 1'b1, $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
